// File: rtl/divider_pkg.sv
// Shared definitions for the iterative signed divider: FSM encoding and iteration count.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int ITERS = 32;
    localparam int CNT_W = $clog2(ITERS);

endpackage

// File: rtl/divider_if.sv
// Start/abort/ready handshake shared by the multdiv stage; the divider sits on the slave side.
interface divider_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_DIV;
    logic             ctrl_MULT;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output data_operandA, data_operandB, ctrl_DIV, ctrl_MULT,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_DIV, ctrl_MULT,
        output data_result, data_exception, data_resultRDY
    );
endinterface

// File: rtl/divider_div_step.sv
// One combinational restoring shift-subtract iteration on unsigned magnitudes.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_next,
    output logic [WIDTH-1:0] q_next
);
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // One extra guard bit keeps the borrow exact for any remainder value.
    always_comb begin
        shifted = {r, q[WIDTH-1]};
        trial   = shifted - {2'b00, d};
        if (trial[WIDTH+1]) begin
            r_next = shifted[WIDTH:0];
            q_next = {q[WIDTH-2:0], 1'b0};
        end else begin
            r_next = trial[WIDTH:0];
            q_next = {q[WIDTH-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/divider.sv
// Signed 32-bit restoring divider: one quotient bit per cycle, quotient truncated toward zero.
//   state | meaning
//   IDLE  | waiting for ctrl_DIV
//   BUSY  | shift-subtract iterations, one per cycle
//   DONE  | sign fix-up, result/exception registered with a one-cycle ready pulse
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic     clock,
    input logic     reset,
    divider_if.slave bus
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    div_state_t       state, state_nx;
    logic             load;
    logic             finish;
    logic [WIDTH-1:0] q, d, q_nx;
    logic [WIDTH:0]   r, r_nx;
    logic [CNT_W-1:0] cnt;
    logic             neg, dbz;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign a_mag = bus.data_operandA[WIDTH-1] ? (~bus.data_operandA + ONE) : bus.data_operandA;
    assign b_mag = bus.data_operandB[WIDTH-1] ? (~bus.data_operandB + ONE) : bus.data_operandB;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r),
        .q      (q),
        .d      (d),
        .r_next (r_nx),
        .q_next (q_nx)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Abort beats start; a start in DONE still lets the finished result out.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        finish   = 1'b0;
        if (bus.ctrl_MULT) begin
            state_nx = IDLE;
        end else begin
            finish = (state == DONE);
            if (bus.ctrl_DIV) begin
                state_nx = BUSY;
                load     = 1'b1;
            end else begin
                case (state)
                    IDLE:    state_nx = IDLE;
                    BUSY:    if (cnt == '0) state_nx = DONE;
                    DONE:    state_nx = IDLE;
                    default: state_nx = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q                  <= '0;
            d                  <= '0;
            r                  <= '0;
            cnt                <= '0;
            neg                <= 1'b0;
            dbz                <= 1'b0;
            bus.data_result    <= '0;
            bus.data_exception <= 1'b0;
            bus.data_resultRDY <= 1'b0;
        end else begin
            if (load) begin
                q   <= a_mag;
                d   <= b_mag;
                r   <= '0;
                cnt <= CNT_W'(ITERS - 1);
                neg <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                dbz <= (bus.data_operandB == '0);
            end else if (state == BUSY) begin
                q   <= q_nx;
                r   <= r_nx;
                cnt <= cnt - CNT_W'(1);
            end
            bus.data_resultRDY <= finish;
            if (finish) begin
                bus.data_result    <= dbz ? '0 : (neg ? (~q + ONE) : q);
                bus.data_exception <= dbz;
            end
        end
    end
endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed corner cases, protocol scenarios and random operands.
module tb_divider;
    logic clock;
    logic reset;
    int   compared   = 0;
    int   mismatched = 0;

    divider_if #(.WIDTH(32)) bus ();

    divider #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: signed division in 64 bits, truncated toward zero.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
        longint qa;
        if (b == 32'd0) return {1'b1, 32'd0};
        qa = longint'($signed(a)) / longint'($signed(b));
        return {1'b0, qa[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives a start pulse; returns at the negedge after the start edge (E0).
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_DIV      = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    // Observes n edges after the call; reports first ready edge index, pulse count and captured outputs.
    task automatic watch(input int n, output int first, output int pulses,
                         output logic [31:0] res, output logic exc);
        first  = -1;
        pulses = 0;
        res    = 'x;
        exc    = 1'bx;
        for (int i = 1; i <= n; i++) begin
            @(posedge clock);
            #1;
            if (bus.data_resultRDY === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first = i;
                    res   = bus.data_result;
                    exc   = bus.data_exception;
                end
            end
        end
    endtask

    task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b);
        int          first, pulses;
        logic [31:0] res;
        logic        exc;
        logic [32:0] exp;
        exp = model(a, b);
        start(a, b);
        watch(40, first, pulses, res, exc);
        chk({tag, "_edge"}, 32'(first), 32'd33);
        chk({tag, "_pulses"}, 32'(pulses), 32'd1);
        chk({tag, "_result"}, res, exp[31:0]);
        chk({tag, "_exc"}, {31'd0, exc}, {31'd0, exp[32]});
    endtask

    initial begin
        int          first, pulses;
        logic [31:0] res;
        logic        exc;
        logic [31:0] a, b;
        logic [32:0] exp;

        reset             = 1'b1;
        bus.ctrl_DIV      = 1'b0;
        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_result", bus.data_result, 32'd0);
        chk("reset_exc", {31'd0, bus.data_exception}, 32'd0);
        chk("reset_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        run_check("p100_7", 32'd100, 32'd7);
        run_check("m100_7", -32'sd100, 32'd7);
        run_check("p100_m7", 32'd100, -32'sd7);
        run_check("m100_m7", -32'sd100, -32'sd7);
        run_check("div0", 32'd7, 32'd0);
        run_check("zero_5", 32'd0, 32'd5);
        run_check("ovf", 32'h8000_0000, 32'hFFFF_FFFF);
        run_check("max_1", 32'h7FFF_FFFF, 32'd1);

        // Abort at E10: no pulse, outputs hold the previous result.
        start(32'd100, 32'd7);
        watch(9, first, pulses, res, exc);
        @(negedge clock);
        bus.ctrl_MULT = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        watch(30, first, pulses, res, exc);
        chk("abort_pulses", 32'(pulses), 32'd0);
        chk("abort_hold", bus.data_result, 32'h7FFF_FFFF);
        run_check("p9_3", 32'd9, 32'd3);

        // Abort and start together: abort wins.
        start(32'd100, 32'd7);
        watch(4, first, pulses, res, exc);
        @(negedge clock);
        bus.ctrl_MULT     = 1'b1;
        bus.ctrl_DIV      = 1'b1;
        bus.data_operandA = 32'd55;
        bus.data_operandB = 32'd5;
        @(posedge clock);
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
        watch(40, first, pulses, res, exc);
        chk("both_pulses", 32'(pulses), 32'd0);

        // Asynchronous reset mid-operation.
        start(32'd100, 32'd7);
        watch(14, first, pulses, res, exc);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("arst_result", bus.data_result, 32'd0);
        chk("arst_exc", {31'd0, bus.data_exception}, 32'd0);
        chk("arst_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        watch(25, first, pulses, res, exc);
        chk("arst_pulses", 32'(pulses), 32'd0);
        run_check("p1000_10", 32'd1000, 32'd10);

        // Restart at E20: only the new operation reports.
        start(32'd100, 32'd7);
        watch(19, first, pulses, res, exc);
        run_check("restart", 32'd50, 32'd5);

        // Back-to-back: start in the DONE cycle; the finished result is still delivered.
        start(-32'sd77, 32'd4);
        watch(32, first, pulses, res, exc);
        chk("b2b_early", 32'(pulses), 32'd0);
        start(32'd1234567, -32'sd89);
        chk("b2b_rdy", {31'd0, bus.data_resultRDY}, 32'd1);
        exp = model(-32'sd77, 32'd4);
        chk("b2b_first", bus.data_result, exp[31:0]);
        watch(40, first, pulses, res, exc);
        exp = model(32'd1234567, -32'sd89);
        chk("b2b_edge", 32'(first), 32'd33);
        chk("b2b_second", res, exp[31:0]);

        for (int k = 0; k < 20; k++) begin
            a = $urandom;
            case ($urandom_range(3))
                0:       b = 32'd0;
                1:       b = 32'($signed($urandom_range(200)) - 100);
                2:       b = $urandom >> $urandom_range(31);
                default: b = $urandom;
            endcase
            if (k % 4 == 0) a = a >>> $urandom_range(24);
            run_check($sformatf("rnd%0d", k), a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
